// File: rtl/game_flow_if.sv
// Control/status bundle between the game-flow controller and the rest of the game:
// player/playfield events in, score-counter controls and pacing strobe out.
interface game_flow_if #(
  parameter int LVL_W = 4
);
  logic             start;
  logic             pause;
  logic             point;
  logic             collide;
  logic             levelup;
  logic             score_en;
  logic             score_clr;
  logic             gameover;
  logic [LVL_W-1:0] level;
  logic             tick;
  logic [1:0]       state;

  modport master (
    output start, pause, point, collide, levelup,
    input  score_en, score_clr, gameover, level, tick, state
  );

  modport slave (
    input  start, pause, point, collide, levelup,
    output score_en, score_clr, gameover, level, tick, state
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// IDLE/PLAY/PAUSE/OVER sequencer: drives the score counter controls, tracks the
// level from levelup edges and emits a level-paced game tick. All outputs registered.
module game_flow_ctrl #(
  parameter int LVL_W       = 4,
  parameter int MAX_LEVEL   = 9,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int PERIOD_STEP = 2_000_000,
  parameter int MIN_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  game_flow_if.slave gf
);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, PAUSE = 2'b10, OVER = 2'b11} state_t;

  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_LEVEL);
  localparam logic [31:0]      BASE    = 32'(BASE_PERIOD);
  localparam logic [31:0]      STEP    = 32'(PERIOD_STEP);
  localparam logic [31:0]      MINP    = 32'(MIN_PERIOD);

  state_t           state_q, state_d;
  logic             score_en_q, score_en_d;
  logic             score_clr_q, score_clr_d;
  logic             gameover_q, gameover_d;
  logic             tick_q, tick_d;
  logic             hist_q, hist_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [31:0] dec, raw_period, period, period_m1;

  // Period shrinks with level; the subtraction is clamped at zero before the floor.
  always_comb begin
    dec        = 32'(level_q) * STEP;
    raw_period = (dec >= BASE) ? 32'd0 : BASE - dec;
    period     = (raw_period < MINP) ? MINP : raw_period;
    period_m1  = (period == 32'd0) ? 32'd0 : period - 32'd1;
  end

  always_comb begin
    state_d     = state_q;
    score_en_d  = 1'b0;
    score_clr_d = 1'b0;
    gameover_d  = 1'b0;
    tick_d      = 1'b0;
    level_d     = level_q;
    cnt_d       = cnt_q;
    hist_d      = gf.levelup;
    case (state_q)
      IDLE: begin
        if (gf.start) begin
          state_d = PLAY;
          level_d = '0;
          cnt_d   = '0;
        end
      end
      PLAY: begin
        if (gf.levelup && !hist_q && (level_q < MAX_LVL)) level_d = level_q + 1'b1;
        if (gf.collide) begin
          state_d = OVER;
        end else begin
          if (gf.pause) state_d = PAUSE;
          score_en_d = gf.point;
          // >= rather than == so a mid-count level-up that shrinks the period still fires.
          if (cnt_q >= period_m1) begin
            tick_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      PAUSE: begin
        if (gf.pause) state_d = PLAY;
      end
      OVER: begin
        if (gf.start) begin
          state_d     = PLAY;
          level_d     = '0;
          cnt_d       = '0;
          score_clr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) score_clr_d = 1'b1;
    gameover_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      score_en_q  <= 1'b0;
      score_clr_q <= 1'b1;
      gameover_q  <= 1'b0;
      tick_q      <= 1'b0;
      hist_q      <= 1'b0;
      level_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      score_en_q  <= score_en_d;
      score_clr_q <= score_clr_d;
      gameover_q  <= gameover_d;
      tick_q      <= tick_d;
      hist_q      <= hist_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gf.state     = state_q;
  assign gf.score_en  = score_en_q;
  assign gf.score_clr = score_clr_q;
  assign gf.gameover  = gameover_q;
  assign gf.tick      = tick_q;
  assign gf.level     = level_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench: stimulus pushes the expected cycle of each tick/score_en pulse,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick_exp[$];
  int   sen_exp[$];

  game_flow_if #(.LVL_W(4)) gf();

  game_flow_ctrl #(
    .LVL_W(4), .MAX_LEVEL(3), .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gf (gf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every pulse must match the head of its expectation queue.
  int got_t;
  always @(negedge clk) begin
    if (gf.tick === 1'b1) begin
      if (tick_exp.size() == 0) check("tick_unexpected_cycle", cyc, 0);
      else begin
        got_t = tick_exp.pop_front();
        check("tick_cycle", cyc, got_t);
      end
    end
    if (gf.score_en === 1'b1) begin
      if (sen_exp.size() == 0) check("score_en_unexpected_cycle", cyc, 0);
      else begin
        got_t = sen_exp.pop_front();
        check("score_en_cycle", cyc, got_t);
      end
    end
  end

  int e, r, t0, t1, t2, t3, t4, s;

  initial begin
    gf.start = 0; gf.pause = 0; gf.point = 0; gf.collide = 0; gf.levelup = 0;
    goto(2);
    rst = 0;
    check("rst_state", gf.state, 0);
    check("rst_score_clr", gf.score_clr, 1);
    check("rst_level", gf.level, 0);
    check("rst_gameover", gf.gameover, 0);
    check("rst_tick", gf.tick, 0);
    check("rst_score_en", gf.score_en, 0);

    // Start: PLAY one cycle later, score_clr drops, ticks every 10 cycles.
    gf.start = 1;
    goto(3);
    gf.start = 0;
    e = cyc;
    check("start_state", gf.state, 1);
    check("start_score_clr", gf.score_clr, 0);
    tick_exp.push_back(e + 10);
    tick_exp.push_back(e + 20);

    // Three points, score_en one cycle after each.
    for (int k = 0; k < 3; k++) begin
      goto(e + 2 + 3 * k);
      sen_exp.push_back(e + 3 + 3 * k);
      gf.point = 1;
      goto(e + 3 + 3 * k);
      gf.point = 0;
    end
    goto(e + 21);
    check("play_state_after_points", gf.state, 1);

    // Pause with simultaneous point: point still scored, counter freezes at 5.
    goto(e + 24);
    sen_exp.push_back(e + 25);
    gf.pause = 1; gf.point = 1;
    goto(e + 25);
    gf.pause = 0; gf.point = 0;
    check("pause_state", gf.state, 2);
    goto(e + 27); gf.point = 1;   goto(e + 28); gf.point = 0;
    goto(e + 29); gf.collide = 1; goto(e + 30); gf.collide = 0;
    gf.levelup = 1;               goto(e + 31); gf.levelup = 0;
    goto(e + 40);
    check("paused_state_hold", gf.state, 2);
    check("paused_level_hold", gf.level, 0);
    goto(e + 45);
    gf.pause = 1;
    goto(e + 46);
    gf.pause = 0;
    r = cyc;
    check("resume_state", gf.state, 1);
    t0 = r + 5;
    tick_exp.push_back(t0);

    // Level-ups right after each tick: intervals 8, 6, 4, 4.
    t1 = t0 + 8; t2 = t1 + 6; t3 = t2 + 4; t4 = t3 + 4;
    tick_exp.push_back(t1); tick_exp.push_back(t2);
    tick_exp.push_back(t3); tick_exp.push_back(t4);
    goto(t0 + 1); gf.levelup = 1;
    goto(t0 + 2); check("level_1", gf.level, 1);
    goto(t0 + 6); gf.levelup = 0;
    goto(t0 + 8); check("level_1_hold_one_edge", gf.level, 1);
    goto(t1 + 1); gf.levelup = 1;
    goto(t1 + 2); gf.levelup = 0; check("level_2", gf.level, 2);
    goto(t2 + 1); gf.levelup = 1;
    goto(t2 + 2); gf.levelup = 0; check("level_3", gf.level, 3);
    goto(t3 + 1); gf.levelup = 1;
    goto(t3 + 2); gf.levelup = 0; check("level_saturate", gf.level, 3);

    // Collide + point exactly when a tick is due: both suppressed.
    goto(t4 + 3);
    gf.collide = 1; gf.point = 1;
    goto(t4 + 4);
    gf.collide = 0; gf.point = 0;
    check("over_state", gf.state, 3);
    check("over_gameover", gf.gameover, 1);
    goto(t4 + 5); gf.pause = 1;   goto(t4 + 6); gf.pause = 0;
    gf.point = 1;                 goto(t4 + 7); gf.point = 0;
    gf.collide = 1;               goto(t4 + 8); gf.collide = 0;
    check("over_ignores_inputs", gf.state, 3);

    // Restart from OVER: one-cycle score_clr, level cleared.
    gf.start = 1;
    goto(t4 + 9);
    gf.start = 0;
    s = cyc;
    check("restart_state", gf.state, 1);
    check("restart_score_clr", gf.score_clr, 1);
    check("restart_level", gf.level, 0);
    check("restart_gameover", gf.gameover, 0);
    tick_exp.push_back(s + 10);
    goto(s + 1);
    check("restart_score_clr_drop", gf.score_clr, 0);
    goto(s + 3); gf.start = 1;
    goto(s + 4); gf.start = 0;
    check("start_in_play_state", gf.state, 1);
    check("start_in_play_score_clr", gf.score_clr, 0);

    // Reach level 2, then reset mid-PLAY together with a point.
    tick_exp.push_back(s + 16);
    goto(s + 11); gf.levelup = 1;
    goto(s + 12); gf.levelup = 0;
    goto(s + 13); gf.levelup = 1;
    goto(s + 14); gf.levelup = 0;
    goto(s + 15); check("pre_rst_level", gf.level, 2);
    goto(s + 17); rst = 1; gf.point = 1;
    goto(s + 18); rst = 0; gf.point = 0;
    check("midrst_state", gf.state, 0);
    check("midrst_level", gf.level, 0);
    check("midrst_score_clr", gf.score_clr, 1);
    check("midrst_tick", gf.tick, 0);
    check("midrst_score_en", gf.score_en, 0);
    check("midrst_gameover", gf.gameover, 0);
    goto(s + 25);
    check("idle_after_rst", gf.state, 0);
    check("idle_score_clr", gf.score_clr, 1);

    while (tick_exp.size() != 0) check("tick_missing_at_cycle", 0, tick_exp.pop_front());
    while (sen_exp.size() != 0) check("score_en_missing_at_cycle", 0, sen_exp.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
